// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ID   = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_RD_TS   = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_CMP     = 3'd5
  } state_e;

  localparam logic        SYSID_ADDR_ID    = 1'b0;
  localparam logic        SYSID_ADDR_TS    = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD5_1302;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5910_3431;

endpackage

// File: rtl/soc_system_sysid_lat_cnt.sv
// Loadable 3-bit down-counter that flags zero; times the readdata latency.
module soc_system_sysid_lat_cnt (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches sysid words 0/1 and compares them to the build values.
// Optional macro SYSID_PERIODIC_CHECK_EN adds periodic re-checks and the mismatch_sticky output.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS  = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY = 1,
  parameter bit          AUTO_START   = 1'b1
`ifdef SYSID_PERIODIC_CHECK_EN
  , parameter int unsigned CHECK_PERIOD = 50_000_000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  check_count
`ifdef SYSID_PERIODIC_CHECK_EN
  , output logic      mismatch_sticky
`endif
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic        auto_q;
  logic        addr_q;
  logic        valid_q, id_match_q, ts_match_q;
  logic [31:0] id_value_q, ts_value_q;
  logic [7:0]  count_q;
  logic        lat_zero, trigger, cap_id, cap_ts;

`ifdef SYSID_PERIODIC_CHECK_EN
  logic [31:0] per_cnt_q;
  logic        per_tick;
  logic        mismatch_q;

  assign per_tick = (per_cnt_q == 32'(CHECK_PERIOD - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      per_cnt_q <= 32'd0;
    end else begin
      per_cnt_q <= per_tick ? 32'd0 : per_cnt_q + 32'd1;
    end
  end

  assign trigger = start | auto_q | per_tick;
`else
  assign trigger = start | auto_q;
`endif

  soc_system_sysid_lat_cnt u_lat_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     ((state_q == ST_RD_ID) || (state_q == ST_RD_TS)),
    .load_val_i (LAT_LOAD),
    .dec_i      ((state_q == ST_WAIT_ID) || (state_q == ST_WAIT_TS)),
    .zero_o     (lat_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (trigger) state_d = ST_RD_ID;
      ST_RD_ID:   state_d = ST_WAIT_ID;
      ST_WAIT_ID: if (lat_zero) state_d = ST_RD_TS;
      ST_RD_TS:   state_d = ST_WAIT_TS;
      ST_WAIT_TS: if (lat_zero) state_d = ST_CMP;
      ST_CMP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sysid_read = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_CMP);
  end

  assign cap_id = (state_q == ST_WAIT_ID) && lat_zero;
  assign cap_ts = (state_q == ST_WAIT_TS) && lat_zero;

  // Results are registered on entry to CMP so they are already visible alongside done.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      auto_q     <= AUTO_START;
      addr_q     <= SYSID_ADDR_ID;
      valid_q    <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      count_q    <= 8'd0;
    end else begin
      auto_q <= 1'b0;
      if (state_d == ST_RD_ID) addr_q <= SYSID_ADDR_ID;
      if (state_d == ST_RD_TS) addr_q <= SYSID_ADDR_TS;
      if (cap_id) id_value_q <= sysid_readdata;
      if (cap_ts) begin
        ts_value_q <= sysid_readdata;
        id_match_q <= (id_value_q == EXPECTED_ID);
        ts_match_q <= (sysid_readdata == EXPECTED_TS);
        valid_q    <= 1'b1;
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end
    end
  end

`ifdef SYSID_PERIODIC_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mismatch_q <= 1'b0;
    end else if (cap_ts && ((id_value_q != EXPECTED_ID) || (sysid_readdata != EXPECTED_TS))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch_sticky = mismatch_q;
`endif

  assign sysid_address = addr_q;
  assign valid         = valid_q;
  assign id_match      = id_match_q;
  assign ts_match      = ts_match_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;
  assign check_count   = count_q;

endmodule
